// File: rtl/tmod_pkg.sv
// Shared opcode, status and state definitions for the temperature-module master.
package tmod_pkg;

    typedef enum logic [3:0] {
        OP_RESET         = 4'd0,
        OP_SET_LOW_TEMP  = 4'd1,
        OP_SET_HIGH_TEMP = 4'd2,
        OP_SET_MODE      = 4'd3,
        OP_OUT_TEMP      = 4'd4,
        OP_OUT_MIN       = 4'd5,
        OP_OUT_MAX       = 4'd6,
        OP_OUT_AVG       = 4'd7,
        OP_NOOP          = 4'd8
    } tmod_op_e;

    // 2'b11 is not named and is treated as OK by every consumer.
    typedef enum logic [1:0] {
        STATUS_OK   = 2'b00,
        STATUS_HIGH = 2'b01,
        STATUS_LOW  = 2'b10
    } tmod_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DONE
    } tmod_state_e;

    // Opcodes 4..7 return data; 0..3 are writes and 8..15 behave as NOOP.
    function automatic logic is_read_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/tmod_alarm_filter.sv
// Debounces one alarm condition: the alarm toggles only after ALARM_CNT
// consecutive cycles in which the condition disagrees with it.
module tmod_alarm_filter #(
    parameter int ALARM_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cond,
    output logic alarm
);

    localparam logic [3:0] CNT_LAST = 4'(ALARM_CNT - 1);

    logic [3:0] cnt_q;
    logic       alarm_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            alarm_q <= 1'b0;
        end else if (cond == alarm_q) begin
            cnt_q <= 4'd0;
        end else if (cnt_q == CNT_LAST) begin
            alarm_q <= ~alarm_q;
            cnt_q   <= 4'd0;
        end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign alarm = alarm_q;

endmodule

// File: rtl/tmod_master.sv
// Command master for the temperature slave: one command in flight, bounded
// waits with timeout, plus continuously filtered high/low alarms.
module tmod_master
    import tmod_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int ALARM_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_opnd,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] bus_op,
    output logic [7:0] bus_opnd,
    input  logic       bus_ready,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    input  logic [1:0] bus_status,
    output logic       alarm_high,
    output logic       alarm_low
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    tmod_state_e state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_err_q;
    logic [3:0]  bus_op_q;
    logic [7:0]  bus_opnd_q;
    logic [7:0]  wait_cnt_q;

    // bus_op/bus_opnd double as the captured command while in ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
            bus_op_q    <= OP_NOOP;
            bus_opnd_q  <= 8'd0;
            wait_cnt_q  <= 8'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        bus_op_q    <= req_op;
                        bus_opnd_q  <= req_opnd;
                        req_ready_q <= 1'b0;
                        rsp_data_q  <= 8'd0;
                        rsp_err_q   <= 1'b0;
                        wait_cnt_q  <= 8'd0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus_ready) begin
                        bus_op_q   <= OP_NOOP;
                        bus_opnd_q <= 8'd0;
                        wait_cnt_q <= 8'd0;
                        if (is_read_op(bus_op_q)) begin
                            state_q <= S_WAIT_RSP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        bus_op_q    <= OP_NOOP;
                        bus_opnd_q  <= 8'd0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_WAIT_RSP: begin
                    if (bus_valid) begin
                        rsp_data_q  <= bus_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign bus_op    = bus_op_q;
    assign bus_opnd  = bus_opnd_q;

    logic cond_high;
    logic cond_low;

    assign cond_high = (bus_status == STATUS_HIGH);
    assign cond_low  = (bus_status == STATUS_LOW);

    tmod_alarm_filter #(.ALARM_CNT(ALARM_CNT)) u_alarm_high (
        .clk   (clk),
        .reset (reset),
        .cond  (cond_high),
        .alarm (alarm_high)
    );

    tmod_alarm_filter #(.ALARM_CNT(ALARM_CNT)) u_alarm_low (
        .clk   (clk),
        .reset (reset),
        .cond  (cond_low),
        .alarm (alarm_low)
    );

endmodule

// File: tb/tb_tmod_master.sv
// Directed bench for tmod_master: write, read, timeout, alarms, reset abort
// and back-to-back commands with hand-computed expectations.
module tb_tmod_master;

    localparam int TIMEOUT   = 16;
    localparam int ALARM_CNT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_opnd;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] bus_op;
    logic [7:0] bus_opnd;
    logic       bus_ready;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic [1:0] bus_status;
    logic       alarm_high;
    logic       alarm_low;

    int n_checks = 0;
    int n_errors = 0;

    tmod_master #(.TIMEOUT(TIMEOUT), .ALARM_CNT(ALARM_CNT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_opnd   (req_opnd),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .bus_op     (bus_op),
        .bus_opnd   (bus_opnd),
        .bus_ready  (bus_ready),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_status (bus_status),
        .alarm_high (alarm_high),
        .alarm_low  (alarm_low)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] opnd);
        req_valid = 1'b1;
        req_op    = op;
        req_opnd  = opnd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'd8;
        req_opnd   = 8'd0;
        bus_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_data   = 8'd0;
        bus_status = 2'b00;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data",  32'(rsp_data),  0);
        check("rst_rsp_err",   32'(rsp_err),   0);
        check("rst_bus_op",    32'(bus_op),    8);
        check("rst_bus_opnd",  32'(bus_opnd),  0);
        check("rst_alarms",    32'({alarm_high, alarm_low}), 0);

        // Write SET_HIGH_TEMP 0x50; stray bus_valid in ISSUE must be ignored
        send(4'd2, 8'h50);
        bus_ready = 1'b1;
        bus_valid = 1'b1;
        bus_data  = 8'hAA;
        cycle();
        req_valid = 1'b0;
        check("wr_bus_op",    32'(bus_op),    2);
        check("wr_bus_opnd",  32'(bus_opnd),  'h50);
        check("wr_req_ready", 32'(req_ready), 0);
        check("wr_no_rsp_1",  32'(rsp_valid), 0);
        cycle();
        bus_ready = 1'b0;
        bus_valid = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 1);
        check("wr_rsp_data",  32'(rsp_data),  0);
        check("wr_rsp_err",   32'(rsp_err),   0);
        check("wr_bus_op_nop", 32'(bus_op),   8);
        cycle();
        check("wr_rsp_pulse", 32'(rsp_valid), 0);
        check("wr_ready_back", 32'(req_ready), 1);

        // Read OUT_MAX returning 0x3C
        send(4'd6, 8'h00);
        bus_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        check("rd_bus_op", 32'(bus_op), 6);
        cycle();
        bus_ready = 1'b0;
        check("rd_wait_bus_op", 32'(bus_op),    8);
        check("rd_wait_no_rsp", 32'(rsp_valid), 0);
        bus_valid = 1'b1;
        bus_data  = 8'h3C;
        cycle();
        bus_valid = 1'b0;
        check("rd_rsp_valid", 32'(rsp_valid), 1);
        check("rd_rsp_data",  32'(rsp_data),  'h3C);
        check("rd_rsp_err",   32'(rsp_err),   0);
        cycle();
        check("rd_rsp_pulse", 32'(rsp_valid), 0);
        check("rd_data_hold", 32'(rsp_data),  'h3C);

        // Timeout: OUT_AVG with bus_ready held low
        send(4'd7, 8'h00);
        cycle();
        req_valid = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            cycle();
            check($sformatf("to_wait_%0d", i), 32'(rsp_valid), 0);
        end
        cycle();
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_rsp_err",   32'(rsp_err),   1);
        check("to_rsp_data",  32'(rsp_data),  0);
        check("to_bus_op",    32'(bus_op),    8);
        cycle();
        check("to_ready_back", 32'(req_ready), 1);
        check("to_err_hold",   32'(rsp_err),   1);

        // Progress on the last allowed ISSUE cycle beats the timeout
        send(4'd1, 8'h12);
        cycle();
        req_valid = 1'b0;
        repeat (TIMEOUT - 1) cycle();
        check("pw_still_issue", 32'(bus_op), 1);
        bus_ready = 1'b1;
        cycle();
        bus_ready = 1'b0;
        check("pw_rsp_valid", 32'(rsp_valid), 1);
        check("pw_rsp_err",   32'(rsp_err),   0);
        cycle();

        // Back-to-back: second command waits for the IDLE cycle after DONE
        send(4'd2, 8'h11);
        bus_ready = 1'b1;
        cycle();
        send(4'd6, 8'h22);
        check("bb_a_bus_op", 32'(bus_op),    2);
        check("bb_a_ready",  32'(req_ready), 0);
        cycle();
        check("bb_a_rsp",      32'(rsp_valid), 1);
        check("bb_a_rsp_data", 32'(rsp_data),  0);
        check("bb_a_ready_done", 32'(req_ready), 0);
        cycle();
        check("bb_idle_ready", 32'(req_ready), 1);
        check("bb_idle_bus_op", 32'(bus_op),   8);
        cycle();
        req_valid = 1'b0;
        check("bb_b_bus_op",   32'(bus_op),   6);
        check("bb_b_bus_opnd", 32'(bus_opnd), 'h22);
        cycle();
        bus_ready = 1'b0;
        bus_valid = 1'b1;
        bus_data  = 8'h77;
        cycle();
        bus_valid = 1'b0;
        check("bb_b_rsp",      32'(rsp_valid), 1);
        check("bb_b_rsp_data", 32'(rsp_data),  'h77);
        cycle();

        // Alarm filtering
        bus_status = 2'b01;
        repeat (3) cycle();
        bus_status = 2'b00;
        repeat (2) cycle();
        check("al_hi_short", 32'(alarm_high), 0);
        bus_status = 2'b01;
        repeat (3) cycle();
        check("al_hi_3", 32'(alarm_high), 0);
        cycle();
        check("al_hi_set", 32'(alarm_high), 1);
        bus_status = 2'b00;
        repeat (3) cycle();
        check("al_hi_hold", 32'(alarm_high), 1);
        cycle();
        check("al_hi_clr", 32'(alarm_high), 0);
        bus_status = 2'b10;
        repeat (4) cycle();
        check("al_lo_set",  32'(alarm_low),  1);
        check("al_lo_nohi", 32'(alarm_high), 0);
        bus_status = 2'b11;
        repeat (3) cycle();
        check("al_lo_hold11", 32'(alarm_low), 1);
        cycle();
        check("al_lo_clr11", 32'(alarm_low), 0);
        bus_status = 2'b10;
        repeat (4) cycle();
        check("al_lo_reset_pre", 32'(alarm_low), 1);
        bus_status = 2'b00;

        // Reset during WAIT_RSP aborts the command
        send(4'd4, 8'h00);
        bus_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        cycle();
        bus_ready = 1'b0;
        check("rm_wait_bus_op", 32'(bus_op), 8);
        reset = 1'b1;
        #1;
        check("rm_async_alarm", 32'(alarm_low), 0);
        check("rm_async_valid", 32'(rsp_valid), 0);
        bus_valid = 1'b1;
        bus_data  = 8'h55;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("rm_no_rsp_%0d", i), 32'(rsp_valid), 0);
        end
        bus_valid = 1'b0;
        check("rm_bus_op",    32'(bus_op),    8);
        check("rm_req_ready", 32'(req_ready), 1);
        check("rm_rsp_data",  32'(rsp_data),  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tmod_master.md
TMOD_MASTER -- requirements
Module: tmod_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles waited in ISSUE or WAIT_RSP before abort (range 2..255).
REQ-002 SHALL have parameter: ALARM_CNT, 4, consecutive status cycles needed to set or clear an alarm (range 1..15).
REQ-003 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: req_valid  in  1  host command request.
REQ-006 SHALL have port: req_ready  out  1  master can accept a command.
REQ-007 SHALL have port: req_op  in  4  command opcode (TMOD_OP).
REQ-008 SHALL have port: req_opnd  in  8  command operand.
REQ-009 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: rsp_data  out  8  read result; 0 for write, NOOP or error.
REQ-011 SHALL have port: rsp_err  out  1  command timed out; qualified by rsp_valid.
REQ-012 SHALL have port: bus_op  out  4  opcode driven to the temperature slave.
REQ-013 SHALL have port: bus_opnd  out  8  operand driven to the slave.
REQ-014 SHALL have port: bus_ready  in  1  slave accepts opcode this cycle.
REQ-015 SHALL have port: bus_valid  in  1  slave read data valid.
REQ-016 SHALL have port: bus_data  in  8  slave read data.
REQ-017 SHALL have port: bus_status  in  2  slave temperature status (TMOD_STATUS).
REQ-018 SHALL have port: alarm_high  out  1  filtered over-temperature alarm.
REQ-019 SHALL have port: alarm_low  out  1  filtered under-temperature alarm.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, DONE.
REQ-021 SHALL assert req_ready only in IDLE; a command is accepted when req_valid and req_ready are both 1, capturing req_op/req_opnd, next state ISSUE.
REQ-022 SHALL drive bus_op with the captured opcode and bus_opnd with the captured operand only in ISSUE; otherwise bus_op = NOOP (4'b1000) and bus_opnd = 0.
REQ-023 SHALL, in ISSUE with bus_ready=1, go to WAIT_RSP for read ops 4..7, or to DONE for write ops 0..3 and NOOP ops 8..15.
REQ-024 SHALL, in WAIT_RSP with bus_valid=1, capture bus_data into rsp_data and go to DONE; bus_valid outside WAIT_RSP is ignored.
REQ-025 SHALL clear an 8-bit wait counter on entry to ISSUE and to WAIT_RSP and increment it each cycle spent there.
REQ-026 SHALL go to DONE with rsp_err=1 and rsp_data=0 when the counter reaches TIMEOUT-1 without progress; progress in that same cycle wins over timeout.
REQ-027 SHALL assert rsp_valid for exactly the one cycle spent in DONE, then return to IDLE; rsp_data and rsp_err hold until the next accept.
REQ-028 SHALL give a minimum read latency of 3 cycles accept-to-rsp_valid (bus_ready and bus_valid on the first possible cycles) and a minimum write latency of 2 cycles.
REQ-029 SHALL keep a 4-bit saturating counter per alarm, counting consecutive cycles that the condition (HIGH for alarm_high, LOW for alarm_low) matches the alarm's opposite state.
REQ-030 SHALL set the alarm when the counter reaches ALARM_CNT, clear it after ALARM_CNT consecutive opposite cycles, and reset the counter whenever the condition agrees with the current alarm value.
REQ-031 SHALL treat bus_status 2'b11 as OK.
REQ-032 SHALL run alarm filtering continuously, independent of FSM state.

Reset
REQ-033 SHALL, on reset, immediately force state IDLE, req_ready=1 (after release), rsp_valid=0, rsp_data=0, rsp_err=0, bus_op=NOOP, bus_opnd=0, alarms=0 and all counters=0.
REQ-034 SHALL abort an in-flight command on reset mid-operation and never emit rsp_valid for it.

Structure
REQ-035 SHALL take TMOD_OP (4-bit opcodes RESET=0 .. OUT_AVG=7, NOOP=8) and TMOD_STATUS (OK=00, HIGH=01, LOW=10) from shared package tmod_pkg.
REQ-036 SHALL implement the alarm filter as sub-module tmod_alarm_filter (params ALARM_CNT; ports clk, reset, cond, alarm), instantiated twice.

Verification
REQ-037 SHALL test a write: accept SET_HIGH_TEMP with opnd 8'h50, bus_ready=1 immediately -> bus_op=2 and bus_opnd=8'h50 for 1 cycle; rsp_valid 2 cycles after accept with rsp_data=0 and rsp_err=0.
REQ-038 SHALL test a read: accept OUT_MAX, then bus_valid with bus_data=8'h3C 2 cycles later -> rsp_valid with rsp_data=8'h3C; bus_op=NOOP during WAIT_RSP.
REQ-039 SHALL test a timeout: accept OUT_AVG with bus_ready held 0 -> rsp_valid with rsp_err=1 and rsp_data=0 exactly TIMEOUT cycles after entering ISSUE; req_ready=1 the following cycle.
REQ-040 SHALL test alarm filtering: bus_status=HIGH for 3 cycles then OK -> alarm_high stays 0; HIGH for 4 cycles -> alarm_high=1; 4 OK cycles -> alarm_high=0.
REQ-041 SHALL test reset mid-operation: reset asserted during WAIT_RSP -> no rsp_valid, bus_op=NOOP, req_ready=1 after release.
REQ-042 SHALL test back-to-back commands: req_valid held high with two commands -> the second is accepted only in the IDLE cycle after DONE, and the two responses are in order.
